// File: rtl/regfile_scoreboard.sv
// ARMv8 general-purpose register file (X0..X30, XZR at 31) with a one-bit-per-register
// scoreboard that stalls decode while a source register has an in-flight producer.
module regfile_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    input  logic        rd_use_a,
    input  logic        rd_use_b,
    output logic [63:0] rd_data_a,
    output logic [63:0] rd_data_b,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [63:0] wr_data,
    input  logic        iss_en,
    input  logic [4:0]  iss_addr,
    output logic        stall,
    output logic [5:0]  pend_cnt
);

    localparam logic [4:0] Xzr = 5'd31;

    logic [63:0] regs_q [0:30];
    logic [63:0] regs_d [0:30];
    logic [30:0] pend_q;
    logic [30:0] pend_d;
    logic [5:0]  pend_cnt_q;
    logic [5:0]  pend_cnt_d;

    logic        wr_ok;
    logic        iss_ok;
    logic        pend_a;
    logic        pend_b;
    logic        haz_a;
    logic        haz_b;

    assign wr_ok  = wr_en && (wr_addr != Xzr);
    assign iss_ok = iss_en && (iss_addr != Xzr);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Set is applied after clear so a same-cycle issue to the written register wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            pend_d[iss_addr] = 1'b1;
        end
    end

    always_comb begin
        pend_cnt_d = 6'd0;
        for (int i = 0; i < 31; i++) begin
            pend_cnt_d = pend_cnt_d + 6'(pend_d[i]);
        end
    end

    always_comb begin
        if (rd_addr_a == Xzr) begin
            rd_data_a = 64'd0;
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = regs_q[rd_addr_a];
        end
    end

    always_comb begin
        if (rd_addr_b == Xzr) begin
            rd_data_b = 64'd0;
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = regs_q[rd_addr_b];
        end
    end

    always_comb begin
        pend_a = 1'b0;
        pend_b = 1'b0;
        if (rd_addr_a != Xzr) begin
            pend_a = pend_q[rd_addr_a];
        end
        if (rd_addr_b != Xzr) begin
            pend_b = pend_q[rd_addr_b];
        end
    end

    // A writeback landing this cycle resolves the hazard through the bypass.
    assign haz_a = rd_use_a && pend_a && !(wr_en && (wr_addr == rd_addr_a));
    assign haz_b = rd_use_b && pend_b && !(wr_en && (wr_addr == rd_addr_b));
    assign stall = haz_a || haz_b;

    assign pend_cnt = pend_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 31; i++) begin
                regs_q[i] <= 64'd0;
            end
            pend_q     <= '0;
            pend_cnt_q <= 6'd0;
        end else begin
            for (int i = 0; i < 31; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expected operands are queued when stimulus is
// driven and popped when the outputs are sampled on the falling edge.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        rd_use_a;
    logic        rd_use_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        stall;
    logic [5:0]  pend_cnt;

    int n_checks;
    int n_fail;

    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];

    localparam logic [63:0] ValX5 = 64'h0123_4567_89AB_CDEF;

    regfile_scoreboard u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_use_a  (rd_use_a),
        .rd_use_b  (rd_use_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .stall     (stall),
        .pend_cnt  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input logic [63:0] a, input logic [63:0] b);
        exp_a_q.push_back(a);
        exp_b_q.push_back(b);
    endtask

    task automatic check_now(input string tag, input logic exp_stall, input logic [5:0] exp_cnt);
        logic [63:0] ea;
        logic [63:0] eb;
        if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            chk({tag, ".rd_data_a"}, rd_data_a, ea);
            chk({tag, ".rd_data_b"}, rd_data_b, eb);
        end
        chk({tag, ".stall"}, 64'(stall), 64'(exp_stall));
        chk({tag, ".pend_cnt"}, 64'(pend_cnt), 64'(exp_cnt));
    endtask

    task automatic sample(input string tag, input logic exp_stall, input logic [5:0] exp_cnt);
        @(negedge clk);
        check_now(tag, exp_stall, exp_cnt);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] zaddr [4];
        logic [4:0] iss_list [3];
        n_checks  = 0;
        n_fail    = 0;
        zaddr     = '{5'd0, 5'd15, 5'd30, 5'd31};
        iss_list  = '{5'd1, 5'd2, 5'd4};
        rst_n     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        rd_use_a  = 1'b0;
        rd_use_b  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_en    = 1'b0;
        iss_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Out of reset every address reads zero.
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = zaddr[i];
            rd_addr_b = zaddr[i];
            expect_rd(64'd0, 64'd0);
            sample($sformatf("reset_rd%0d", zaddr[i]), 1'b0, 6'd0);
            next_cycle();
        end

        // Write X5: bypass in the same cycle, storage afterwards.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = ValX5;
        rd_addr_a = 5'd5; rd_addr_b = 5'd0;
        expect_rd(ValX5, 64'd0);
        sample("x5_bypass", 1'b0, 6'd0);
        next_cycle();

        wr_en = 1'b0;
        expect_rd(ValX5, 64'd0);
        sample("x5_stored", 1'b0, 6'd0);
        next_cycle();

        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
        rd_addr_b = 5'd31;
        expect_rd(ValX5, 64'd0);
        sample("xzr_write", 1'b0, 6'd0);
        next_cycle();

        // Issue X7, stall on use, resolve via same-cycle writeback.
        wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd7;
        rd_addr_b = 5'd7;
        expect_rd(ValX5, 64'd0);
        sample("x7_issue", 1'b0, 6'd0);
        next_cycle();

        iss_en = 1'b0; rd_use_b = 1'b1;
        expect_rd(ValX5, 64'd0);
        sample("x7_stall", 1'b1, 6'd1);
        next_cycle();

        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h42;
        expect_rd(ValX5, 64'h42);
        sample("x7_wb_bypass", 1'b0, 6'd1);
        next_cycle();

        wr_en = 1'b0;
        expect_rd(ValX5, 64'h42);
        sample("x7_cleared", 1'b0, 6'd0);
        next_cycle();

        // Same-cycle issue and writeback to X9: set wins, data still stored.
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h10;
        rd_use_b = 1'b0; rd_addr_b = 5'd9;
        expect_rd(ValX5, 64'h10);
        sample("x9_iss_wb", 1'b0, 6'd0);
        next_cycle();

        iss_en = 1'b0; wr_en = 1'b0; rd_use_b = 1'b1;
        expect_rd(ValX5, 64'h10);
        sample("x9_set_wins", 1'b1, 6'd1);
        next_cycle();

        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h11; rd_use_b = 1'b0;
        expect_rd(ValX5, 64'h11);
        sample("x9_retire", 1'b0, 6'd1);
        next_cycle();

        // Issue X3 then XZR; only X3 becomes pending.
        wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd3; rd_addr_b = 5'd0;
        expect_rd(ValX5, 64'd0);
        sample("x3_issue", 1'b0, 6'd0);
        next_cycle();

        iss_addr = 5'd31;
        expect_rd(ValX5, 64'd0);
        sample("xzr_issue", 1'b0, 6'd1);
        next_cycle();

        iss_en = 1'b0; rd_addr_a = 5'd3; rd_use_a = 1'b0;
        expect_rd(64'd0, 64'd0);
        sample("x3_nouse", 1'b0, 6'd1);
        next_cycle();

        rd_use_a = 1'b1;
        expect_rd(64'd0, 64'd0);
        sample("x3_use", 1'b1, 6'd1);
        next_cycle();

        rd_addr_a = 5'd31;
        expect_rd(64'd0, 64'd0);
        sample("xzr_use", 1'b0, 6'd1);
        next_cycle();

        // Issue X1, X2, X4 and then reset between edges.
        rd_use_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iss_en = 1'b1; iss_addr = iss_list[i];
            expect_rd(64'd0, 64'd0);
            sample($sformatf("multi_issue%0d", i), 1'b0, 6'(i + 1));
            next_cycle();
        end

        iss_en = 1'b0; rd_addr_a = 5'd1; rd_use_a = 1'b1; rd_addr_b = 5'd5;
        expect_rd(64'd0, ValX5);
        sample("pre_reset", 1'b1, 6'd4);

        rst_n = 1'b0;
        #2;
        expect_rd(64'd0, 64'd0);
        check_now("async_reset", 1'b0, 6'd0);
        next_cycle();
        rst_n = 1'b1;
        expect_rd(64'd0, 64'd0);
        sample("post_reset", 1'b0, 6'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

ARMv8 general-purpose register file with an integrated single-bit-per-register scoreboard. It receives the two read addresses produced by the decode-stage read-address selection (Rn and the Rm/Rt select output) and returns 64-bit operands. It accepts one writeback per cycle and raises a decode stall when a source register still has an in-flight producer. X31 is the zero register (XZR) on every port.

## Interface

- No parameters; data width 64, 32 architectural registers.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_addr_a`  in  5  read port A address (Rn).
- `rd_addr_b`  in  5  read port B address (selected Rm/Rt).
- `rd_use_a`  in  1  port A operand is consumed by the instruction in decode.
- `rd_use_b`  in  1  port B operand is consumed by the instruction in decode.
- `rd_data_a`  out  64  port A operand, combinational.
- `rd_data_b`  out  64  port B operand, combinational.
- `wr_en`  in  1  writeback strobe.
- `wr_addr`  in  5  writeback destination.
- `wr_data`  in  64  writeback value.
- `iss_en`  in  1  instruction leaving decode with a register destination.
- `iss_addr`  in  5  that instruction's destination.
- `stall`  out  1  decode must hold; combinational.
- `pend_cnt`  out  6  number of pending registers, registered.

## Operation

- Storage: `regs[0..30]` 64-bit, `pend[0..30]` 1-bit. No storage for index 31.
- Read: `rd_data_x` = 0 if addr = 31. Otherwise it is `wr_data` if `wr_en` and `wr_addr` = addr (write-through bypass). Otherwise it is `regs[addr]`.
- Write: on an edge with `wr_en` and `wr_addr` != 31, `regs[wr_addr]` <= `wr_data`. Writes to 31 are discarded silently.
- Scoreboard set: on an edge with `iss_en` and `iss_addr` != 31, `pend[iss_addr]` <= 1.
- Scoreboard clear: on an edge with `wr_en` and `wr_addr` != 31, `pend[wr_addr]` <= 0, unless the set rule targets the same index in the same cycle. Set wins: the newer producer is still outstanding.
- Writing a non-pending register is legal; data is stored and `pend` stays 0. No error is raised.
- Issuing to an already-pending register is legal; the bit stays 1. The scoreboard does not count multiple producers.
- Hazard per port x: `haz_x` = `rd_use_x` & addr != 31 & `pend[addr]` & !(`wr_en` & `wr_addr` = addr). A same-cycle writeback resolves the hazard through the bypass.
- `stall` = `haz_a` | `haz_b`.
- The block does not gate `iss_en` with `stall`. Upstream must not assert `iss_en` while `stall` = 1. If it does, the block still applies the set rule.
- `pend_cnt` = population count of `pend`, as a registered copy of next-state `pend`. Range 0..31.

## Timing

- Reset (asynchronous, `rst_n` = 0): all `regs` = 0, all `pend` = 0, `pend_cnt` = 0.
  - Then `rd_data_a`/`rd_data_b` = 0 for any address, except the bypass path still follows `wr_en`/`wr_data` combinationally.
  - `stall` = 0.
- Reset asserted mid-operation discards all pending state immediately; it does not wait for a clock edge.
- Reads have 0-cycle latency (combinational from address and write inputs).
- A write is visible:
  - in the same cycle via the bypass;
  - from `regs` starting the cycle after the edge.
- `pend` bit changes take effect on `stall` in the cycle after the edge.
- `pend_cnt` reflects the edge's updates in the same cycle as `pend`.
- No internal FSM; state is `regs`, `pend` and `pend_cnt` only.

## Test plan

- Reset, then read addresses 0, 15, 30, 31 on both ports -> all read 0; `stall` = 0; `pend_cnt` = 0.
- Write X5 = 0x0123_4567_89AB_CDEF; read port A addr 5 in the same cycle -> bypass value. Next cycle with `wr_en` = 0 -> same value from storage. Write X31 = 0xFFFF…F -> port B addr 31 reads 0.
- Issue X7.
  - Next cycle: `rd_use_b` = 1, `rd_addr_b` = 7 -> `stall` = 1, `pend_cnt` = 1.
  - Writeback X7 = 0x42 -> `stall` = 0 in that cycle and `rd_data_b` = 0x42.
  - Following cycle: `pend_cnt` = 0.
- Same cycle `iss_en` X9 and `wr_en` X9 = 0x10 -> next cycle `pend[9]` = 1 (`stall` = 1 on use of X9), `regs[9]` = 0x10.
- Issue X3 and X31, then set `rd_use_a` = 0 with `rd_addr_a` = 3 -> `pend_cnt` = 1, `stall` = 0. Set `rd_use_a` = 1 -> `stall` = 1. Read addr 31 with use -> no stall.
- Issue X1, X2, X4; assert `rst_n` = 0 between edges -> `pend_cnt` = 0 and `stall` = 0 immediately; X1 reads 0.
